warp_ibuffer: RTL

Synthesizable per-warp instruction buffer that replaces the simulation-only frontend model's instruction-buffer heads. It sits between fetch/decode and the issue stage and holds NUM_WARPS independent FIFOs of decoded instruction entries. A credit/reservation scheme guarantees fetch never over-runs a queue. Per-warp flush discards both queued and in-flight instructions.

---
 rtl/warp_ibuffer_pkg.sv | 30 +++
 rtl/warp_ibuffer_chk.sv | 20 ++
 rtl/warp_ibuffer_queue.sv | 124 ++++++++++++
 rtl/warp_ibuffer.sv | 80 ++++++++
 4 files changed

// File: rtl/warp_ibuffer_pkg.sv
// Shared types for the per-warp instruction buffer: the packed decoded-entry layout and its width.
package warp_ibuffer_pkg;

    localparam int OP_BITS      = 7;
    localparam int REG_BITS     = 8;
    localparam int CSR_IMM_BITS = 8;
    localparam int PRED_BITS    = 4;
    localparam int NUM_LANES    = 16;
    localparam int INST_BITS    = 64;

    typedef struct packed {
        logic [31:0]             pc;
        logic [OP_BITS-1:0]      op;
        logic [REG_BITS-1:0]     rd;
        logic [REG_BITS-1:0]     rs1;
        logic [REG_BITS-1:0]     rs2;
        logic [REG_BITS-1:0]     rs3;
        logic [31:0]             imm32;
        logic [23:0]             imm24;
        logic [CSR_IMM_BITS-1:0] csr_imm;
        logic [2:0]              f3;
        logic [6:0]              f7;
        logic [PRED_BITS-1:0]    pred;
        logic [NUM_LANES-1:0]    tmask;
        logic [INST_BITS-1:0]    raw;
    } ibuf_entry_t;

    localparam int ENTRY_BITS = $bits(ibuf_entry_t);

endpackage

// File: rtl/warp_ibuffer_chk.sv
// Protocol checker for warp_ibuffer: responses must match a reservation, flushed heads stay hidden.
module warp_ibuffer_chk #(
    parameter int NUM_WARPS = 8,
    parameter int WID_BITS  = $clog2(NUM_WARPS)
) (
    input logic                 clock,
    input logic                 reset_n,
    input logic                 enq_valid,
    input logic [WID_BITS-1:0]  enq_wid,
    input logic [NUM_WARPS-1:0] rsv_empty,
    input logic [NUM_WARPS-1:0] ibuf_valid,
    input logic [NUM_WARPS-1:0] flush_mask
);
    enq_needs_reservation: assert property (
        @(posedge clock) disable iff (!reset_n) enq_valid |-> !rsv_empty[enq_wid]);

    flush_hides_head: assert property (
        @(posedge clock) disable iff (!reset_n) (ibuf_valid & flush_mask) == {NUM_WARPS{1'b0}});

endmodule

// File: rtl/warp_ibuffer_queue.sv
// Single-warp instruction FIFO with occupancy, reservation and drop counters.
// Optional same-cycle head bypass when IBUF_BYPASS_EN is defined.
module warp_ibuffer_queue
    import warp_ibuffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rsv_fire,
    input  logic                  enq_valid,
    input  logic [ENTRY_BITS-1:0] enq_entry,
    input  logic                  flush,
    input  logic                  deq_ready,
    output logic                  head_valid,
    output logic [ENTRY_BITS-1:0] head_entry,
    output logic [CNT_BITS-1:0]   credits,
    output logic                  rsv_empty
);
    localparam int                  PTR_BITS  = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] ZERO_C    = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] ONE_C     = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] DEPTH_C   = CNT_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_ONE_C = {{(PTR_BITS-1){1'b0}}, 1'b1};

    logic [ENTRY_BITS-1:0] mem_r [DEPTH];
    logic [PTR_BITS-1:0]   head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [CNT_BITS-1:0]   occ_r, rsv_r, drop_r;
    logic [CNT_BITS-1:0]   occ_nxt_s, rsv_nxt_s, drop_nxt_s;
    logic [CNT_BITS-1:0]   enq_cnt_s, fire_cnt_s, push_cnt_s, pop_cnt_s;
    logic                  discard_s, bypass_s, push_s, pop_s;

    // A response is thrown away while earlier flushes still owe drops, or when flushed this cycle.
    assign discard_s = flush || (drop_r != ZERO_C);

`ifdef IBUF_BYPASS_EN
    assign bypass_s   = enq_valid && !discard_s && (occ_r == ZERO_C) && deq_ready;
    assign head_valid = !flush && ((occ_r != ZERO_C) || bypass_s);
    assign head_entry = (occ_r == ZERO_C) ? enq_entry : mem_r[head_r];
`else
    assign bypass_s   = 1'b0;
    assign head_valid = !flush && (occ_r != ZERO_C);
    assign head_entry = mem_r[head_r];
`endif

    assign push_s     = enq_valid && !discard_s && !bypass_s;
    assign pop_s      = (occ_r != ZERO_C) && deq_ready && !flush;
    assign enq_cnt_s  = {{(CNT_BITS-1){1'b0}}, enq_valid};
    assign fire_cnt_s = {{(CNT_BITS-1){1'b0}}, rsv_fire};
    assign push_cnt_s = {{(CNT_BITS-1){1'b0}}, push_s};
    assign pop_cnt_s  = {{(CNT_BITS-1){1'b0}}, pop_s};
    assign rsv_empty  = (rsv_r == ZERO_C);

    // Next-state computation for pointers and counters
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        occ_nxt_s  = occ_r;
        drop_nxt_s = drop_r;
        rsv_nxt_s  = rsv_r + fire_cnt_s - enq_cnt_s;
        if (flush) begin
            head_nxt_s = {PTR_BITS{1'b0}};
            tail_nxt_s = {PTR_BITS{1'b0}};
            occ_nxt_s  = ZERO_C;
            drop_nxt_s = rsv_r - enq_cnt_s;
        end else begin
            if (push_s) begin
                tail_nxt_s = tail_r + PTR_ONE_C;
            end else begin
                tail_nxt_s = tail_r;
            end
            if (pop_s) begin
                head_nxt_s = head_r + PTR_ONE_C;
            end else begin
                head_nxt_s = head_r;
            end
            occ_nxt_s = occ_r + push_cnt_s - pop_cnt_s;
            if (enq_valid && (drop_r != ZERO_C)) begin
                drop_nxt_s = drop_r - ONE_C;
            end else begin
                drop_nxt_s = drop_r;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r <= {PTR_BITS{1'b0}};
            tail_r <= {PTR_BITS{1'b0}};
            occ_r  <= ZERO_C;
            rsv_r  <= ZERO_C;
            drop_r <= ZERO_C;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            occ_r  <= occ_nxt_s;
            rsv_r  <= rsv_nxt_s;
            drop_r <= drop_nxt_s;
        end
    end

    // Entry storage, cleared on reset so the head output reads zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_BITS{1'b0}};
            end
        end else if (push_s) begin
            mem_r[tail_r] <= enq_entry;
        end
    end

    // Free slots; reads zero while reset is held
    always_comb begin
        if (reset_n) begin
            credits = DEPTH_C - occ_r - rsv_r;
        end else begin
            credits = ZERO_C;
        end
    end

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer top: warp-id decode, NUM_WARPS queues, output flattening.
// Define IBUF_BYPASS_EN to present an enqueue to an empty, ready warp in the same cycle.
module warp_ibuffer
    import warp_ibuffer_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int DEPTH     = 4,
    parameter int WID_BITS  = $clog2(NUM_WARPS),
    parameter int CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            rsv_valid,
    input  logic [WID_BITS-1:0]             rsv_wid,
    output logic                            rsv_ready,
    input  logic                            enq_valid,
    input  logic [WID_BITS-1:0]             enq_wid,
    input  logic [ENTRY_BITS-1:0]           enq_entry,
    input  logic [NUM_WARPS-1:0]            flush_mask,
    input  logic [NUM_WARPS-1:0]            ibuf_ready,
    output logic [NUM_WARPS-1:0]            ibuf_valid,
    output logic [NUM_WARPS*ENTRY_BITS-1:0] ibuf_entry,
    output logic [NUM_WARPS*CNT_BITS-1:0]   credits
);
    logic [CNT_BITS-1:0]  credits_s [NUM_WARPS];
    logic [NUM_WARPS-1:0] rsv_empty_s;
    logic                 rsv_ready_s;

    // Grant a reservation when the addressed warp has a free, unflushed slot
    always_comb begin
        if ((credits_s[rsv_wid] != {CNT_BITS{1'b0}}) && !flush_mask[rsv_wid]) begin
            rsv_ready_s = 1'b1;
        end else begin
            rsv_ready_s = 1'b0;
        end
    end

    assign rsv_ready = rsv_ready_s;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic rsv_hit_s;
        logic enq_hit_s;

        assign rsv_hit_s = rsv_valid && rsv_ready_s && (rsv_wid == WID_BITS'(w));
        assign enq_hit_s = enq_valid && (enq_wid == WID_BITS'(w));

        warp_ibuffer_queue #(
            .DEPTH    (DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_queue (
            .clock      (clock),
            .reset_n    (reset_n),
            .rsv_fire   (rsv_hit_s),
            .enq_valid  (enq_hit_s),
            .enq_entry  (enq_entry),
            .flush      (flush_mask[w]),
            .deq_ready  (ibuf_ready[w]),
            .head_valid (ibuf_valid[w]),
            .head_entry (ibuf_entry[ENTRY_BITS*w +: ENTRY_BITS]),
            .credits    (credits_s[w]),
            .rsv_empty  (rsv_empty_s[w])
        );

        assign credits[CNT_BITS*w +: CNT_BITS] = credits_s[w];
    end

    warp_ibuffer_chk #(
        .NUM_WARPS (NUM_WARPS),
        .WID_BITS  (WID_BITS)
    ) u_chk (
        .clock      (clock),
        .reset_n    (reset_n),
        .enq_valid  (enq_valid),
        .enq_wid    (enq_wid),
        .rsv_empty  (rsv_empty_s),
        .ibuf_valid (ibuf_valid),
        .flush_mask (flush_mask)
    );

endmodule
